serial_byte_loader: RTL and testbench
=====================================

SERIAL_BYTE_LOADER -- requirements
Module: serial_byte_loader

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = first received bit lands in byte_out[7], 0 = first received bit lands in byte_out[0].
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock of the block.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets).
REQ-004 SHALL have port sin  input  1  serial data bit.
REQ-005 SHALL have port sin_valid  input  1  sin carries a valid bit this cycle.
REQ-006 SHALL have port sin_ready  output  1  block accepts a bit this cycle.
REQ-007 SHALL have port byte_out  output  8  assembled byte, feeds the downstream 8-bit register D input.
REQ-008 SHALL have port byte_valid  output  1  byte_out holds a complete byte.
REQ-009 SHALL have port byte_ready  input  1  downstream consumes byte_out this cycle.
REQ-010 SHALL have port parity_err  output  1  one-cycle pulse on parity mismatch.
REQ-011 SHALL have port byte_count  output  8  number of bytes delivered, modulo 256.

Function
REQ-012 SHALL be an FSM with states COLLECT, PARITY (present only with the macro) and HOLD, plus a 3-bit bit counter and an 8-bit shift register.
REQ-013 SHALL accept a bit only on a rising edge where sin_valid==1 and sin_ready==1; sin is ignored at all other times.
REQ-014 SHALL drive sin_ready=1 in COLLECT and PARITY, sin_ready=0 in HOLD and while rst==0.
REQ-015 With MSB_FIRST=1, SHALL shift left with the new bit entering bit 0; with MSB_FIRST=0, SHALL shift right with the new bit entering bit 7.
REQ-016 SHALL increment the bit counter per accepted data bit, wrapping 7->0 on the 8th bit.
REQ-017 With the macro off, SHALL enter HOLD, load byte_out and set byte_valid=1 on the edge that accepts the 8th bit; byte_valid is visible in the next cycle (1-cycle latency).
REQ-018 In HOLD, SHALL keep byte_out and byte_valid stable until an edge with byte_ready==1.
REQ-019 On an edge in HOLD with byte_ready==1, SHALL return to COLLECT, clear byte_valid, increment byte_count (255 wraps to 0), and clear the bit counter.
REQ-020 byte_ready outside HOLD SHALL have no effect.
REQ-021 byte_out SHALL change only when entering HOLD or on reset; partial bytes are never visible on byte_out.
REQ-022 Gaps (sin_valid==0) between bits SHALL not disturb partial assembly.

Reset
REQ-023 On an edge with rst==0, SHALL set state=COLLECT, bit counter=0, shift register=0, byte_out=8'h00, byte_valid=0, parity_err=0, byte_count=8'h00.
REQ-024 Reset SHALL take priority over every other event, including simultaneous bit acceptance or byte_ready.
REQ-025 Reset mid-byte or in HOLD SHALL discard the partial or held byte without incrementing byte_count.

Configuration
REQ-026 Macro SERIAL_PARITY_CHECK_EN: when defined, after the 8th data bit SHALL go to PARITY and accept one more bit as even parity (XOR of 8 data bits and parity bit must be 0).
REQ-027 With the macro defined and parity correct, SHALL enter HOLD on the edge accepting the parity bit (byte_valid one cycle later); on a mismatch, SHALL pulse parity_err for exactly one cycle, return to COLLECT, discard the byte, and leave byte_count unchanged.
REQ-028 Without the macro, SHALL omit the PARITY state, follow REQ-017, and tie parity_err to 0.

Verification
REQ-029 Reset: hold rst=0 for 2 edges with sin_valid=1 -> byte_out=00, byte_valid=0, byte_count=00, sin_ready=0 during reset, 1 after.
REQ-030 MSB_FIRST=1, macro off, bits 1,0,1,0,0,1,0,1 back-to-back -> byte_valid=1 one cycle after the 8th edge, byte_out=A5; byte_ready=1 -> byte_valid=0, byte_count=01.
REQ-031 MSB_FIRST=0, same bit stream with 3-cycle sin_valid gaps -> byte_out=A5 (bit0 first: 1,0,1,0,0,1,0,1), unaffected by the gaps.
REQ-032 Backpressure: byte_ready=0 for 10 cycles in HOLD while sin_valid=1 -> sin_ready=0, byte_out stable; 256 delivered bytes -> byte_count wraps to 00.
REQ-033 Macro on: data 8'h03 with parity 0 -> byte_out=03, byte_valid=1; data 8'h03 with parity 1 -> parity_err pulse of 1 cycle, no byte_valid, byte_count unchanged.
REQ-034 rst=0 after 5 of 8 bits, then a full byte of 8'h3C -> byte_out=3C; the 5 partial bits do not appear.

Source files
------------

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel byte assembler with valid/ready handshakes on both sides.
// Define SERIAL_PARITY_CHECK_EN to require an even-parity bit after each byte.
module serial_byte_loader #(
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_valid,
    output logic       sin_ready,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       parity_err,
    output logic [7:0] byte_count
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        HOLD    = 2'd1
`ifdef SERIAL_PARITY_CHECK_EN
        ,
        PARITY  = 2'd2
`endif
    } state_t;

    state_t     state_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] byte_q;
    logic       valid_q;
    logic [7:0] count_q;
    logic       accept;

    // Readiness depends on rst directly so no bit is taken while reset is held.
    assign sin_ready  = rst && (state_q != HOLD);
    assign accept     = sin_valid && sin_ready;
    assign shift_d    = (MSB_FIRST != 0) ? {shift_q[6:0], sin} : {sin, shift_q[7:1]};
    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign byte_count = count_q;

`ifdef SERIAL_PARITY_CHECK_EN
    logic perr_q;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= COLLECT;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            byte_q   <= 8'h00;
            valid_q  <= 1'b0;
            count_q  <= 8'h00;
`ifdef SERIAL_PARITY_CHECK_EN
            perr_q   <= 1'b0;
`endif
        end else begin
`ifdef SERIAL_PARITY_CHECK_EN
            perr_q <= 1'b0;
`endif
            case (state_q)
                COLLECT: begin
                    if (accept) begin
                        shift_q  <= shift_d;
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
`ifdef SERIAL_PARITY_CHECK_EN
                            state_q <= PARITY;
`else
                            state_q <= HOLD;
                            byte_q  <= shift_d;
                            valid_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef SERIAL_PARITY_CHECK_EN
                PARITY: begin
                    if (accept) begin
                        if ((^shift_q ^ sin) == 1'b0) begin
                            state_q <= HOLD;
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= COLLECT;
                            perr_q  <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (byte_ready) begin
                        state_q  <= COLLECT;
                        valid_q  <= 1'b0;
                        count_q  <= count_q + 8'd1;
                        bitcnt_q <= 3'd0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_byte_loader.sv
// Bench driving MSB-first and LSB-first loaders from one shared bit stream,
// with a byte scoreboard per instance.
module tb_serial_byte_loader;

    logic       clk = 1'b0;
    logic       rst, sin, sin_valid, byte_ready;
    logic       rdy0, rdy1, bv0, bv1, pe0, pe1;
    logic [7:0] bo0, bo1, bc0, bc1;

    always #5 clk = ~clk;

    serial_byte_loader #(.MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(rdy0),
        .byte_out(bo0), .byte_valid(bv0), .byte_ready(byte_ready),
        .parity_err(pe0), .byte_count(bc0)
    );

    serial_byte_loader #(.MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_ready(rdy1),
        .byte_out(bo1), .byte_valid(bv1), .byte_ready(byte_ready),
        .parity_err(pe1), .byte_count(bc1)
    );

    int         npass = 0;
    int         ntotal = 0;
    logic [7:0] exp_msb[$];
    logic [7:0] exp_lsb[$];
    logic [7:0] exp_cnt = 8'h00;

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bits go out b[7] first; the LSB-first instance therefore assembles rev8(b).
    task automatic drive_byte(input logic [7:0] b, input int gap, input logic bad_par);
        if (!bad_par) begin
            exp_msb.push_back(b);
            exp_lsb.push_back(rev8(b));
        end
        for (int i = 7; i >= 0; i--) begin
            sin = b[i];
            sin_valid = 1'b1;
            tick();
            sin_valid = 1'b0;
            sin = 1'b0;
            if (i > 0) repeat (gap) tick();
        end
`ifdef SERIAL_PARITY_CHECK_EN
        repeat (gap) tick();
        sin = (^b) ^ bad_par;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
        sin = 1'b0;
`endif
    endtask

    task automatic collect_and_ack();
        int n = 0;
        logic [7:0] e0, e1;
        while (!(bv0 && bv1) && n < 30) begin
            tick();
            n++;
        end
        ntotal++;
        if (!(bv0 && bv1)) $display("FAIL byte_valid_timeout got %b/%b need 1/1", bv0, bv1);
        else npass++;
        ntotal++;
        if (exp_msb.size() == 0) begin
            $display("FAIL scoreboard_empty got byte %h with no expected entry", bo0);
        end else begin
            npass++;
            e0 = exp_msb.pop_front();
            e1 = exp_lsb.pop_front();
            ntotal++;
            if (bo0 !== e0) $display("FAIL byte_out_msb got %h need %h", bo0, e0);
            else npass++;
            ntotal++;
            if (bo1 !== e1) $display("FAIL byte_out_lsb got %h need %h", bo1, e1);
            else npass++;
        end
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        ntotal++;
        if (bv0 !== 1'b0 || bv1 !== 1'b0) $display("FAIL valid_after_ack got %b/%b need 0/0", bv0, bv1);
        else npass++;
        ntotal++;
        if (bc0 !== exp_cnt || bc1 !== exp_cnt) $display("FAIL byte_count got %h/%h need %h", bc0, bc1, exp_cnt);
        else npass++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        exp_msb.delete();
        exp_lsb.delete();
        exp_cnt = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sin = 1'b1;
        sin_valid = 1'b1;
        byte_ready = 1'b0;
        repeat (2) begin
            tick();
            ntotal++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0) $display("FAIL ready_in_reset got %b/%b need 0/0", rdy0, rdy1);
            else npass++;
        end
        ntotal++;
        if (bo0 !== 8'h00 || bo1 !== 8'h00) $display("FAIL reset_byte_out got %h/%h need 00", bo0, bo1);
        else npass++;
        ntotal++;
        if (bv0 !== 1'b0 || bv1 !== 1'b0 || pe0 !== 1'b0 || pe1 !== 1'b0)
            $display("FAIL reset_valid_perr got %b%b%b%b need 0000", bv0, bv1, pe0, pe1);
        else npass++;
        ntotal++;
        if (bc0 !== 8'h00 || bc1 !== 8'h00) $display("FAIL reset_count got %h/%h need 00", bc0, bc1);
        else npass++;
        rst = 1'b1;
        sin_valid = 1'b0;
        sin = 1'b0;
        #1;
        ntotal++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) $display("FAIL ready_after_reset got %b/%b need 1/1", rdy0, rdy1);
        else npass++;
    endtask

    task automatic test_back_to_back();
        drive_byte(8'hA5, 0, 1'b0);
        ntotal++;
        if (bv0 !== 1'b1 || bv1 !== 1'b1) $display("FAIL valid_latency got %b/%b need 1/1", bv0, bv1);
        else npass++;
        collect_and_ack();
    endtask

    task automatic test_gaps();
        drive_byte(8'hA5, 3, 1'b0);
        collect_and_ack();
        drive_byte(8'h1E, 2, 1'b0);
        collect_and_ack();
    endtask

    task automatic test_ready_outside_hold();
        byte_ready = 1'b1;
        repeat (3) tick();
        byte_ready = 1'b0;
        ntotal++;
        if (bc0 !== exp_cnt || bv0 !== 1'b0) $display("FAIL ready_outside_hold got cnt %h valid %b need %h 0", bc0, bv0, exp_cnt);
        else npass++;
    endtask

    task automatic test_backpressure();
        drive_byte(8'h96, 0, 1'b0);
        byte_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sin = 1'($urandom_range(0, 1));
            sin_valid = 1'b1;
            tick();
            ntotal++;
            if (rdy0 !== 1'b0 || rdy1 !== 1'b0) $display("FAIL bp_ready got %b/%b need 0/0", rdy0, rdy1);
            else npass++;
            ntotal++;
            if (bo0 !== 8'h96 || bo1 !== 8'h69 || bv0 !== 1'b1)
                $display("FAIL bp_hold got %h/%h valid %b need 96/69 1", bo0, bo1, bv0);
            else npass++;
        end
        sin_valid = 1'b0;
        sin = 1'b0;
        collect_and_ack();
    endtask

    task automatic test_wrap();
        while (exp_cnt != 8'h00) begin
            drive_byte(8'($urandom), 0, 1'b0);
            collect_and_ack();
        end
        ntotal++;
        if (bc0 !== 8'h00 || bc1 !== 8'h00) $display("FAIL count_wrap got %h/%h need 00", bc0, bc1);
        else npass++;
    endtask

    task automatic test_reset_midbyte();
        for (int i = 0; i < 5; i++) begin
            sin = 1'b1;
            sin_valid = 1'b1;
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sin_valid = 1'b0;
        sin = 1'b0;
        exp_cnt = 8'h00;
        ntotal++;
        if (bo0 !== 8'h00 || bv0 !== 1'b0 || bc0 !== 8'h00)
            $display("FAIL midbyte_reset got %h valid %b cnt %h need 00 0 00", bo0, bv0, bc0);
        else npass++;
        drive_byte(8'h3C, 0, 1'b0);
        collect_and_ack();
        drive_byte(8'h81, 0, 1'b0);
        ntotal++;
        if (bv0 !== 1'b1) $display("FAIL hold_before_reset got valid %b need 1", bv0);
        else npass++;
        byte_ready = 1'b1;
        do_reset();
        byte_ready = 1'b0;
        ntotal++;
        if (bv0 !== 1'b0 || bv1 !== 1'b0 || bo0 !== 8'h00 || bc0 !== 8'h00)
            $display("FAIL hold_reset got valid %b/%b byte %h cnt %h need 0/0 00 00", bv0, bv1, bo0, bc0);
        else npass++;
    endtask

`ifdef SERIAL_PARITY_CHECK_EN
    task automatic test_parity();
        drive_byte(8'h03, 0, 1'b0);
        collect_and_ack();
        drive_byte(8'h03, 0, 1'b1);
        ntotal++;
        if (pe0 !== 1'b1 || pe1 !== 1'b1 || bv0 !== 1'b0)
            $display("FAIL parity_pulse got %b/%b valid %b need 1/1 0", pe0, pe1, bv0);
        else npass++;
        tick();
        ntotal++;
        if (pe0 !== 1'b0 || pe1 !== 1'b0 || bv0 !== 1'b0 || bc0 !== exp_cnt)
            $display("FAIL parity_after got %b/%b valid %b cnt %h need 0/0 0 %h", pe0, pe1, bv0, bc0, exp_cnt);
        else npass++;
    endtask
`endif

    initial begin
        #500us;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_ready_outside_hold();
        test_backpressure();
        test_wrap();
        test_reset_midbyte();
`ifdef SERIAL_PARITY_CHECK_EN
        test_parity();
`endif
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
